// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM oversampling interpolator family.
package pcm_pkg;

    localparam int PCM_BITS    = 16;
    localparam int PCM_OS_LOG2 = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        LOAD  = ST_LOAD,
        RUN   = ST_RUN
    } pcm_state_t;

    typedef logic signed [PCM_BITS-1:0] pcm_sample_t;

endpackage

// File: rtl/pcm_lerp.sv
// Combinational linear interpolator: prev + ((cur - prev) * phase) >>> OS_LOG2.
module pcm_lerp
    import pcm_pkg::*;
#(
    parameter int BITS    = PCM_BITS,
    parameter int OS_LOG2 = PCM_OS_LOG2
) (
    input  logic signed [BITS-1:0]    prev,
    input  logic signed [BITS-1:0]    cur,
    input  logic        [OS_LOG2-1:0] phase,
    output logic signed [BITS-1:0]    lerp
);

    logic signed [BITS:0]         diff;
    logic signed [BITS+OS_LOG2:0] prod;

    // The result lies between prev and cur, so truncating back to BITS is lossless.
    always_comb begin
        diff = {cur[BITS-1], cur} - {prev[BITS-1], prev};
        prod = $signed({{OS_LOG2{diff[BITS]}}, diff}) * $signed({{(BITS+1){1'b0}}, phase});
        lerp = prev + BITS'(prod >>> OS_LOG2);
    end

endmodule

// File: rtl/pcm_os_interpolator.sv
// FIFO-fed linear interpolator producing one sample per oversample strobe.
// Optional PCM_INTERP_UNDERRUN_MUTE_EN: on a starved fetch ramp to zero instead of holding.
//
// state | meaning
// IDLE  | waiting for the first sample in the FIFO, output held at 0
// FETCH | issue the FIFO read, or flag underrun when the FIFO is empty
// LOAD  | FIFO data valid: shift cur into prev and capture the new cur
// RUN   | emit one interpolated sample per os_ce, fetch after the last phase
module pcm_os_interpolator
    import pcm_pkg::*;
#(
    parameter int BITS    = PCM_BITS,
    parameter int OS_LOG2 = PCM_OS_LOG2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            os_ce,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    input  logic [BITS-1:0] fifo_rd_data,
    output logic [BITS-1:0] out,
    output logic            out_ce,
    output logic            underrun,
    output logic            active
);

    localparam logic [OS_LOG2-1:0] PH_LAST = '1;

    pcm_state_t               state, state_nxt;
    logic signed [BITS-1:0]   prev, cur, lerp;
    logic        [OS_LOG2-1:0] phase;

    pcm_lerp #(.BITS(BITS), .OS_LOG2(OS_LOG2)) u_lerp (
        .prev  (prev),
        .cur   (cur),
        .phase (phase),
        .lerp  (lerp)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = FETCH;
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = LOAD;
                end else begin
                    state_nxt  = RUN;
                end
            end
            LOAD:  state_nxt = RUN;
            RUN:   if (os_ce && phase == PH_LAST) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out      <= '0;
            out_ce   <= 1'b0;
            underrun <= 1'b0;
            active   <= 1'b0;
            prev     <= '0;
            cur      <= '0;
            phase    <= '0;
        end else begin
            out_ce <= 1'b0;
            case (state)
                FETCH: begin
                    if (fifo_empty) begin
                        prev     <= cur;
                        underrun <= 1'b1;
`ifdef PCM_INTERP_UNDERRUN_MUTE_EN
                        cur      <= '0;
`endif
                    end
                end
                LOAD: begin
                    prev     <= cur;
                    cur      <= fifo_rd_data;
                    underrun <= 1'b0;
                    active   <= 1'b1;
                end
                RUN: begin
                    if (os_ce) begin
                        out    <= lerp;
                        out_ce <= 1'b1;
                        phase  <= phase + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_os_interpolator.sv
// Scoreboard bench for pcm_os_interpolator: directed strobes push expected samples, a monitor checks out_ce.
module tb_pcm_os_interpolator;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        os_ce = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data = '0;
    logic [15:0] out;
    logic        out_ce;
    logic        underrun;
    logic        active;

    int total = 0;
    int bad = 0;

    logic [15:0] fifo_mem [0:127];
    int push_cnt = 0;
    int pop_cnt = 0;
    int exp_mem [0:511];
    int exp_wr = 0;
    int exp_rd = 0;
    int oce_cnt = 0;
    bit ur_seen = 0;

    pcm_os_interpolator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .os_ce        (os_ce),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .out          (out),
        .out_ce       (out_ce),
        .underrun     (underrun),
        .active       (active)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (push_cnt == pop_cnt);

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic fifo_push(input int v);
        fifo_mem[push_cnt] = 16'(v);
        push_cnt++;
    endtask

    // One oversample strobe at 4-clk spacing; the expected sample goes to the scoreboard.
    task automatic strobe(input int e);
        exp_mem[exp_wr] = e;
        exp_wr++;
        os_ce = 1'b1;
        @(negedge clk);
        os_ce = 1'b0;
        chk("out_ce_latency", int'(out_ce), 1);
        ur_seen |= underrun;
        repeat (3) @(negedge clk);
    endtask

    // FIFO model: data is valid the clk after the read pulse.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            chk("os_ce_during_fetch", int'(os_ce), 0);
            fifo_rd_data <= fifo_mem[pop_cnt];
            pop_cnt <= pop_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && out_ce) begin
            oce_cnt++;
            if (exp_rd == exp_wr) begin
                chk("out_ce_unexpected", 1, 0);
            end else begin
                chk("out", s16(out), exp_mem[exp_rd]);
                exp_rd++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected done");
        $fatal(1, "watchdog");
    end

    int vec [24] = '{0, 0, 0, 0,
                     0, 100, 200, 300,
                     400, -7892, -16184, -24476,
                     -32768, -16385, -1, 16383,
                     32767, 16383, -1, -16385,
                     -32768, -24326, -15884, -7442};
`ifdef PCM_INTERP_UNDERRUN_MUTE_EN
    int ur1 [4] = '{1000, 750, 500, 250};
    int ur2 [4] = '{0, 0, 0, 0};
    int refl [4] = '{0, 500, 1000, 1500};
    int ur3 [2] = '{2000, 1500};
`else
    int ur1 [4] = '{1000, 1000, 1000, 1000};
    int ur2 [4] = '{1000, 1000, 1000, 1000};
    int refl [4] = '{1000, 1250, 1500, 1750};
    int ur3 [2] = '{2000, 2000};
`endif

    initial begin
        int base_pop;
        int base_oce;
        int lat;
        bit found;

        repeat (2) @(negedge clk);
        chk("rst_out", s16(out), 0);
        chk("rst_out_ce", int'(out_ce), 0);
        chk("rst_fifo_rd_en", int'(fifo_rd_en), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_active", int'(active), 0);

        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        os_ce = 1'b1;
        @(negedge clk);
        os_ce = 1'b0;
        chk("idle_ignores_os_ce", int'(out_ce), 0);
        chk("idle_out", s16(out), 0);
        chk("idle_no_read", pop_cnt, 0);
        repeat (2) @(negedge clk);

        fifo_push(0);
        fifo_push(400);
        fifo_push(-32768);
        fifo_push(32767);
        fifo_push(-32768);
        fifo_push(1000);
        repeat (4) @(negedge clk);
        chk("active_after_load", int'(active), 1);
        chk("underrun_after_load", int'(underrun), 0);

        for (int i = 0; i < 24; i++) strobe(vec[i]);
        chk("underrun_set", int'(underrun), 1);
        chk("reads_before_underrun", pop_cnt, 6);
        chk("active_during_underrun", int'(active), 1);

        for (int i = 0; i < 4; i++) strobe(ur1[i]);
        strobe(ur2[0]);
        fifo_push(2000);
        strobe(ur2[1]);
        strobe(ur2[2]);
        chk("underrun_held", int'(underrun), 1);
        strobe(ur2[3]);
        chk("underrun_clear_on_load", int'(underrun), 0);
        chk("reads_after_refill", pop_cnt, 7);
        for (int i = 0; i < 4; i++) strobe(refl[i]);
        for (int i = 0; i < 2; i++) strobe(ur3[i]);
        chk("underrun_before_reset", int'(underrun), 1);
        chk("out_before_reset", s16(out), ur3[1]);

        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_out", s16(out), 0);
        chk("async_rst_out_ce", int'(out_ce), 0);
        chk("async_rst_fifo_rd_en", int'(fifo_rd_en), 0);
        chk("async_rst_underrun", int'(underrun), 0);
        chk("async_rst_active", int'(active), 0);

        for (int k = 0; k < 64; k++) fifo_push(400 * k);
        @(negedge clk);
        base_pop = pop_cnt;
        base_oce = oce_cnt;
        reset_n = 1'b1;
        found = 1'b0;
        lat = 0;
        for (int i = 1; i <= 3 && !found; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                found = 1'b1;
                lat = i;
            end
        end
        chk("fetch_within_2clk_of_release", int'(found && lat <= 2), 1);
        repeat (3) @(negedge clk);
        chk("active_after_rst_reload", int'(active), 1);

        ur_seen = 1'b0;
        for (int j = 0; j < 256; j++) begin
            int k;
            int p;
            k = j / 4;
            p = j % 4;
            strobe((k == 0) ? 0 : 400 * (k - 1) + 100 * p);
        end
        repeat (4) @(negedge clk);
        chk("cadence_reads", pop_cnt - base_pop, 64);
        chk("cadence_out_ce", oce_cnt - base_oce, 256);
        chk("cadence_no_underrun", int'(ur_seen), 0);
        chk("underrun_after_drain", int'(underrun), 1);
        chk("scoreboard_drained", exp_wr - exp_rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
